fifo_rd_ctrl: RTL and testbench

//  Read-side pointer/flag controller of the camera-to-VGA async FIFO (VGA pixel clock domain).

---
 rtl/fifo_rd_ctrl_if.sv | 26 ++
 rtl/fifo_rd_ctrl.sv | 59 +++++
 tb/tb_fifo_rd_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle between the VGA pixel fetch and the async FIFO read controller.
// Carries the read request, the synchronized write pointer, and all read-domain status.
// The master modport is the fetch/sync side; the slave modport is the controller.
interface fifo_rd_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              rd_en;
  logic [ADDR_W:0]   rq2_wptr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   rptr;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_level;
  logic              rd_valid;
  logic              underflow;

  modport master (
    output rd_en, rq2_wptr,
    input  raddr, rptr, empty, almost_empty, rd_level, rd_valid, underflow
  );

  modport slave (
    input  rd_en, rq2_wptr,
    output raddr, rptr, empty, almost_empty, rd_level, rd_valid, underflow
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer/flag controller of the camera-to-VGA async FIFO.
// Latency: flags/level update at the edge after a read or rq2_wptr change; rd_valid 1 cycle after read.
// Backpressure: a read is taken only when rd_en=1 and empty=0; rd_en while empty pulses underflow.
module fifo_rd_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int AE_THRESH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_rd_ctrl_if.slave  bus
);

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rbin_next;
  logic [ADDR_W:0] wbin;
  logic [ADDR_W:0] level_next;
  logic [ADDR_W:0] rptr_next;
  logic            rd_ok;

  // The registered empty flag is the only gate on a read, so there is no input->output path.
  assign rd_ok      = bus.rd_en & ~bus.empty;
  assign rbin_next  = rbin + {{ADDR_W{1'b0}}, rd_ok};
  assign rptr_next  = (rbin_next >> 1) ^ rbin_next;
  assign level_next = wbin - rbin_next;

  // RAM address comes straight from the binary pointer register.
  assign bus.raddr = rbin[ADDR_W-1:0];

  // Gray-to-binary of the synchronized write pointer: bit i is the XOR of all gray bits >= i.
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      wbin[i] = ^(bus.rq2_wptr >> i);
    end
  end

  // Pointer, flag and level registers; flags are computed from the post-read pointer so the
  // last read sets empty at the same edge, and synchronizer lag only delays empty deassertion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbin             <= '0;
      bus.rptr         <= '0;
      bus.empty        <= 1'b1;
      bus.almost_empty <= 1'b1;
      bus.rd_level     <= '0;
      bus.rd_valid     <= 1'b0;
      bus.underflow    <= 1'b0;
    end else begin
      rbin             <= rbin_next;
      bus.rptr         <= rptr_next;
      bus.empty        <= (rptr_next == bus.rq2_wptr);
      bus.almost_empty <= (level_next <= (ADDR_W+1)'(AE_THRESH));
      bus.rd_level     <= level_next;
      bus.rd_valid     <= rd_ok;
      bus.underflow    <= bus.rd_en & bus.empty;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomized bench for fifo_rd_ctrl against a count-based reference model.
// Latency: checks every output 1 time unit after each rising edge.
// Backpressure: model accepts a read only when its own view of empty is clear.
module tb_fifo_rd_ctrl;

  logic clk;
  logic rst_n;
  fifo_rd_ctrl_if #(.ADDR_W(9)) bus();

  fifo_rd_ctrl #(.ADDR_W(9), .AE_THRESH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // Reference model: plain counts of reads and writes modulo 1024.
  int m_rd;
  int m_w;
  bit m_empty;
  bit m_ae;
  int m_level;
  bit m_valid;
  bit m_uf;

  function automatic logic [9:0] gray(input int b);
    logic [9:0] x;
    x = b[9:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model by the rules of the block, check all outputs.
  task automatic step(input bit rst, input bit rd, input int w);
    bit acc;
    logic [9:0] prev_rptr;
    rst_n        = ~rst;
    bus.rd_en    = rd;
    m_w          = w % 1024;
    bus.rq2_wptr = gray(m_w);
    prev_rptr    = bus.rptr;
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      m_rd = 0; m_empty = 1; m_ae = 1; m_level = 0; m_valid = 0; m_uf = 0;
    end else begin
      acc     = rd && !m_empty;
      m_uf    = rd && m_empty;
      m_valid = acc;
      if (acc) m_rd = (m_rd + 1) % 1024;
      m_level = (m_w - m_rd + 1024) % 1024;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= 4);
    end
    #1;
    chk("raddr", 32'(bus.raddr), 32'(m_rd % 512));
    chk("rptr", 32'(bus.rptr), 32'(gray(m_rd)));
    chk("empty", 32'(bus.empty), 32'(m_empty));
    chk("almost_empty", 32'(bus.almost_empty), 32'(m_ae));
    chk("rd_level", 32'(bus.rd_level), 32'(m_level));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    chk("underflow", 32'(bus.underflow), 32'(m_uf));
    if (acc) chk("gray_1bit", 32'($countones(bus.rptr ^ prev_rptr)), 32'd1);
  endtask

  initial begin
    int w;
    n_vec = 0; n_bad = 0;
    m_rd = 0; m_w = 0; m_empty = 1; m_ae = 1; m_level = 0; m_valid = 0; m_uf = 0;
    rst_n = 1'b0; bus.rd_en = 1'b0; bus.rq2_wptr = '0;

    // T1 reset
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t1_empty", 32'(bus.empty), 32'd1);
    chk("t1_level", 32'(bus.rd_level), 32'd0);

    // T2 basic read of three entries
    step(0, 0, 3);
    chk("t2_level", 32'(bus.rd_level), 32'd3);
    step(0, 1, 3);
    step(0, 1, 3);
    step(0, 1, 3);
    chk("t2_rptr", 32'(bus.rptr), 32'h002);
    chk("t2_empty", 32'(bus.empty), 32'd1);
    step(0, 0, 3);

    // T3 underflow
    step(0, 1, 3);
    chk("t3_underflow", 32'(bus.underflow), 32'd1);
    step(0, 0, 3);

    // T4 almost-empty threshold
    w = m_rd + 5;
    step(0, 0, w);
    chk("t4_level5", 32'(bus.rd_level), 32'd5);
    step(0, 1, w);
    chk("t4_ae", 32'(bus.almost_empty), 32'd1);
    while (!m_empty) step(0, 1, w);

    // T5 full and double wrap
    step(1, 0, 0);
    step(0, 0, 512);
    chk("t5_full", 32'(bus.rd_level), 32'd512);
    for (int i = 0; i < 512; i++) step(0, 1, 512);
    chk("t5_rptr_half", 32'(bus.rptr), 32'h300);
    step(0, 0, 1024);
    for (int i = 0; i < 512; i++) step(0, 1, 1024);
    chk("t5_rptr_wrap", 32'(bus.rptr), 32'h000);
    chk("t5_empty", 32'(bus.empty), 32'd1);

    // T6 reset mid-stream with a pending read
    w = m_rd + 10;
    step(0, 0, w);
    step(0, 1, w);
    step(1, 1, 0);
    chk("t6_rst_valid", 32'(bus.rd_valid), 32'd0);
    step(0, 1, 0);
    step(0, 1, 0);
    chk("t6_underflow", 32'(bus.underflow), 32'd1);
    step(0, 1, 2);
    step(0, 1, 2);
    step(0, 1, 2);

    // Random traffic with occasional resets; writes never push the level above 512
    w = m_w;
    for (int i = 0; i < 3000; i++) begin
      int inc;
      bit r;
      inc = $urandom_range(0, 3);
      if (((w - m_rd + 1024) % 1024) + inc > 512) inc = 0;
      w = (w + inc) % 1024;
      r = ($urandom_range(0, 199) == 0);
      if (r) w = 0;
      step(r, 1'($urandom_range(0, 1)), w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
